// File: rtl/rf_debug_access_pkg.sv
// Shared types and constants for the register-file debug initiator.
package pkg_rf_debug;

    localparam int RF_DBG_ADDR_W = 5;
    localparam int RF_DBG_XLEN   = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_HALT,
        ACCESS,
        RSP
    } rf_dbg_state_t;

endpackage

// File: rtl/rf_debug_access.sv
// Debug-side register-file initiator. It halts the core, owns the RF port
// for one ACCESS cycle per beat, and returns one response per beat.
module rf_debug_access
    import pkg_rf_debug::*;
#(
    parameter int XLEN     = RF_DBG_XLEN,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = RF_DBG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              core_halt_req,
    input  logic              core_halted,
    output logic              dbg_owns_rf,
    output logic [ADDR_W-1:0] rf_addr_read,
    output logic [ADDR_W-1:0] rf_addr_write,
    output logic              rf_write_en,
    output logic [XLEN-1:0]   rf_write_data,
    input  logic [XLEN-1:0]   rf_read_data
);

    localparam logic [ADDR_W:0] LAST_REG = (ADDR_W+1)'(NUM_REGS - 1);

    rf_dbg_state_t     state, state_n;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;

    // One bit wider than the index so a range past the top never wraps.
    logic [ADDR_W:0]   end_addr;
    logic              range_err;
    logic              more_beats;

    assign end_addr   = {1'b0, cur_addr} + {1'b0, remaining};
    assign range_err  = !wr_q && (end_addr > LAST_REG);
    assign more_beats = !wr_q && !err_q && (remaining != '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and all outputs, decoded from the current state.
    always_comb begin
        state_n       = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_last      = 1'b0;
        rsp_err       = 1'b0;
        core_halt_req = 1'b0;
        dbg_owns_rf   = 1'b0;
        rf_addr_read  = '0;
        rf_addr_write = '0;
        rf_write_en   = 1'b0;
        rf_write_data = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = CHECK;
            end
            CHECK: begin
                state_n = range_err ? RSP : WAIT_HALT;
            end
            WAIT_HALT: begin
                core_halt_req = 1'b1;
                if (core_halted) state_n = ACCESS;
            end
            ACCESS: begin
                core_halt_req = 1'b1;
                dbg_owns_rf   = 1'b1;
                rf_addr_read  = cur_addr;
                if (wr_q) begin
                    rf_addr_write = cur_addr;
                    rf_write_data = wdata_q;
                    // Never write unless the core confirms it is stalled.
                    rf_write_en   = core_halted;
                end
                state_n = RSP;
            end
            RSP: begin
                rsp_valid     = 1'b1;
                rsp_rdata     = rdata_q;
                rsp_err       = err_q;
                rsp_last      = err_q || wr_q || (remaining == '0);
                core_halt_req = !err_q;
                dbg_owns_rf   = !err_q;
                if (rsp_ready) state_n = more_beats ? ACCESS : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Latched request fields, burst progress and response data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    wr_q      <= req_write;
                    err_q     <= 1'b0;
                    cur_addr  <= req_addr;
                    remaining <= req_len;
                    wdata_q   <= req_wdata;
                    rdata_q   <= '0;
                end
                CHECK: if (range_err) err_q <= 1'b1;
                ACCESS: rdata_q <= wr_q ? '0 : rf_read_data;
                RSP: if (rsp_ready && more_beats) begin
                    remaining <= remaining - 1'b1;
                    cur_addr  <= cur_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_debug_access.sv
// Directed bench for rf_debug_access with a behavioural register file.
module tb_rf_debug_access;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_addr, req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_rdata;
    logic        core_halt_req, core_halted, dbg_owns_rf;
    logic [4:0]  rf_addr_read, rf_addr_write;
    logic        rf_write_en;
    logic [31:0] rf_write_data, rf_read_data;

    int errs = 0;
    int checks = 0;

    rf_debug_access dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .core_halt_req(core_halt_req), .core_halted(core_halted),
        .dbg_owns_rf(dbg_owns_rf),
        .rf_addr_read(rf_addr_read), .rf_addr_write(rf_addr_write),
        .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
        .rf_read_data(rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: x0 reads as zero, preload port for setup.
    logic [31:0] rf [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_write_en && rf_addr_write != 5'd0) rf[rf_addr_write] <= rf_write_data;
    end
    assign rf_read_data = (rf_addr_read == 5'd0) ? 32'd0 : rf[rf_addr_read];

    // Activity counters sampled mid-cycle.
    int we_cnt = 0, halt_cnt = 0, own_cnt = 0, rsp_cnt = 0;
    logic [4:0] we_addr = '0;
    always @(negedge clk) begin
        if (rf_write_en) begin we_cnt++; we_addr = rf_addr_write; end
        if (core_halt_req) halt_cnt++;
        if (dbg_owns_rf) own_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_en = 1'b0;
    endtask

    // Present a request for one edge; returns at the negedge after acceptance.
    task automatic send_req(input logic w, input logic [4:0] a, input logic [4:0] l,
                            input logic [31:0] d);
        @(negedge clk);
        chk("req_ready before send", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!rsp_valid) chk({tag, " rsp timeout"}, rsp_valid, 1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int s_we, s_halt, s_own, s_rsp;
    logic [31:0] burst_exp [3];

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_len = '0; req_wdata = '0; rsp_ready = 1'b0; core_halted = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #12;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset halt_req", core_halt_req, 0);
        chk("reset owns_rf", dbg_owns_rf, 0);
        chk("reset write_en", rf_write_en, 0);
        @(negedge clk); reset = 1'b1;

        // Single read of x5, cycle by cycle.
        preload(5'd5, 32'hDEADBEEF);
        send_req(1'b0, 5'd5, 5'd0, 32'd0);
        chk("rd CHECK req_ready", req_ready, 0);
        chk("rd CHECK halt_req", core_halt_req, 0);
        @(negedge clk);
        chk("rd WAIT halt_req", core_halt_req, 1);
        chk("rd WAIT owns_rf", dbg_owns_rf, 0);
        @(negedge clk);
        chk("rd ACCESS owns_rf", dbg_owns_rf, 1);
        chk("rd ACCESS addr", rf_addr_read, 5);
        chk("rd ACCESS rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("rd T+4 rsp_valid", rsp_valid, 1);
        chk("rd x5 data", rsp_rdata, 32'hDEADBEEF);
        chk("rd x5 last", rsp_last, 1);
        chk("rd x5 err", rsp_err, 0);
        accept();
        chk("rd done rsp_valid", rsp_valid, 0);
        chk("rd done halt_req", core_halt_req, 0);
        chk("rd done owns_rf", dbg_owns_rf, 0);
        chk("rd done req_ready", req_ready, 1);

        // Write x15, then read it back.
        s_we = we_cnt;
        send_req(1'b1, 5'd15, 5'd0, 32'h12345678);
        wait_rsp("wr15");
        chk("wr15 err", rsp_err, 0);
        chk("wr15 last", rsp_last, 1);
        chk("wr15 rdata", rsp_rdata, 0);
        accept();
        chk("wr15 we pulses", we_cnt - s_we, 1);
        chk("wr15 we addr", we_addr, 15);
        send_req(1'b0, 5'd15, 5'd0, 32'd0);
        wait_rsp("rb15");
        chk("rb15 data", rsp_rdata, 32'h12345678);
        accept();

        // Write with req_len ignored: no range error at the top register.
        send_req(1'b1, 5'd31, 5'd31, 32'hA5A5A5A5);
        wait_rsp("wr31");
        chk("wr31 err", rsp_err, 0);
        chk("wr31 last", rsp_last, 1);
        accept();

        // Write x0 is performed, reading x0 stays zero.
        s_we = we_cnt;
        send_req(1'b1, 5'd0, 5'd0, 32'h12345678);
        wait_rsp("wr0");
        chk("wr0 err", rsp_err, 0);
        accept();
        chk("wr0 we pulses", we_cnt - s_we, 1);
        chk("wr0 we addr", we_addr, 0);
        send_req(1'b0, 5'd0, 5'd0, 32'd0);
        wait_rsp("rd0");
        chk("rd0 data", rsp_rdata, 0);
        accept();

        // Burst read x10..x12 with back-pressure on every beat.
        preload(5'd10, 32'hCAFEBABE);
        preload(5'd11, 32'h00000001);
        preload(5'd12, 32'h00000002);
        burst_exp[0] = 32'hCAFEBABE; burst_exp[1] = 32'h1; burst_exp[2] = 32'h2;
        send_req(1'b0, 5'd10, 5'd2, 32'd0);
        for (int b = 0; b < 3; b++) begin
            wait_rsp($sformatf("burst%0d", b));
            chk($sformatf("burst%0d data", b), rsp_rdata, burst_exp[b]);
            chk($sformatf("burst%0d last", b), rsp_last, (b == 2) ? 1 : 0);
            repeat (2) @(negedge clk);
            chk($sformatf("burst%0d held valid", b), rsp_valid, 1);
            chk($sformatf("burst%0d held data", b), rsp_rdata, burst_exp[b]);
            accept();
        end
        chk("burst done req_ready", req_ready, 1);

        // Out-of-range read: error response, no halt, no RF access.
        s_we = we_cnt; s_halt = halt_cnt; s_own = own_cnt;
        send_req(1'b0, 5'd30, 5'd3, 32'd0);
        wait_rsp("err");
        chk("err flag", rsp_err, 1);
        chk("err last", rsp_last, 1);
        chk("err rdata", rsp_rdata, 0);
        accept();
        chk("err halt cycles", halt_cnt - s_halt, 0);
        chk("err own cycles", own_cnt - s_own, 0);
        chk("err we pulses", we_cnt - s_we, 0);

        // Core never halts, then reset lands during the wait.
        core_halted = 1'b0;
        send_req(1'b0, 5'd5, 5'd0, 32'd0);
        s_we = we_cnt; s_own = own_cnt;
        repeat (10) @(negedge clk);
        chk("nohalt halt_req", core_halt_req, 1);
        chk("nohalt own cycles", own_cnt - s_own, 0);
        chk("nohalt we pulses", we_cnt - s_we, 0);
        chk("nohalt rsp_valid", rsp_valid, 0);
        #2 reset = 1'b0;
        #1;
        chk("async rst req_ready", req_ready, 1);
        chk("async rst halt_req", core_halt_req, 0);
        chk("async rst owns_rf", dbg_owns_rf, 0);
        s_rsp = rsp_cnt;
        @(negedge clk); reset = 1'b1; core_halted = 1'b1;
        repeat (8) @(negedge clk);
        chk("post rst rsp cycles", rsp_cnt - s_rsp, 0);
        chk("post rst req_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
